// File: rtl/ltssm_pkg.sv
// ltssm_pkg: timer codes, code-to-ms lookup and substate encodings shared across the LTSSM
package ltssm_pkg;
  localparam logic [5:0] TMR_OFF  = 6'd0;
  localparam logic [5:0] TMR_2MS  = 6'd1;
  localparam logic [5:0] TMR_12MS = 6'd2;
  localparam logic [5:0] TMR_24MS = 6'd3;
  localparam logic [5:0] TMR_48MS = 6'd4;
  localparam logic [5:0] TMR_1MS  = 6'd5;
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} tmr_state_e;
  typedef enum logic [3:0] {
    DETECT_QUIET, DETECT_ACTIVE, POLLING_ACTIVE, POLLING_CONFIG,
    CONFIG_LINKWIDTH, CONFIG_IDLE, L0, RECOVERY
  } ltssm_substate_e;
  // zero means disarmed or reserved; callers tell those apart by the code itself
  function automatic logic [5:0] code_to_ms(input logic [5:0] code);
    return code == TMR_2MS  ? 6'd2  :
           code == TMR_12MS ? 6'd12 :
           code == TMR_24MS ? 6'd24 :
           code == TMR_48MS ? 6'd48 :
           code == TMR_1MS  ? 6'd1  : 6'd0;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: cycle prescaler emitting a one-cycle tick every CPM enabled cycles
module ms_tick_gen #(
  parameter int CPM = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int PW = CPM > 1 ? $clog2(CPM) : 1;
  localparam logic [PW-1:0] LAST = PW'(CPM - 1);
  logic [PW-1:0] cnt_q, cnt_d;
  assign tick_o = en_i & ~clr_i & (cnt_q == LAST);
  always_comb begin
    cnt_d = clr_i ? '0 : tick_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ltssm_timeout_timer.sv
// ltssm_timeout_timer: programmable ms timeout for the RX LTSSM; LTSSM_TIMER_SCALE_EN selects SIM_CYCLES_PER_MS
module ltssm_timeout_timer
  import ltssm_pkg::*;
#(
  parameter int CYCLES_PER_MS     = 1000000,
  parameter int SIM_CYCLES_PER_MS = 4,
  parameter int MS_W              = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] setTimer,
  input  logic       enableTimer,
  input  logic       resetTimer,
  output logic       timeOut,
  output logic       timerBusy,
  output logic       timerCodeErr
);
`ifdef LTSSM_TIMER_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif
  localparam int CPM = SCALE ? SIM_CYCLES_PER_MS : CYCLES_PER_MS;
  tmr_state_e      state_q, state_d;
  logic [MS_W-1:0] limit_q, limit_d, ms_q, ms_d, ms_inc;
  logic            to_q, to_d, busy_q, busy_d, err_q, err_d;
  logic            tick;
  ms_tick_gen #(.CPM(CPM)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr_i (resetTimer | (state_q != RUN)),
    .en_i  (enableTimer),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    ms_d    = ms_q;
    to_d    = to_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ms_inc  = ms_q + 1'b1;
    if (resetTimer) begin
      state_d = IDLE;
      limit_d = '0;
      ms_d    = '0;
      to_d    = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b0;
    end else if (state_q == IDLE && enableTimer) begin
      if (code_to_ms(setTimer) != 6'd0) begin
        limit_d = MS_W'(code_to_ms(setTimer));
        state_d = RUN;
        busy_d  = 1'b1;
      end
      err_d = err_q | (setTimer > TMR_1MS);
    end else if (state_q == RUN && tick) begin
      ms_d = ms_inc;
      if (ms_inc == limit_q) begin
        state_d = EXPIRED;
        to_d    = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      limit_q <= '0;
      ms_q    <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      ms_q    <= ms_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end
  assign timeOut      = to_q;
  assign timerBusy    = busy_q;
  assign timerCodeErr = err_q;
endmodule

// File: tb/tb_ltssm_timeout_timer.sv
// tb_ltssm_timeout_timer: scoreboard bench for the timeout timer with 4 cycles per ms
module tb_ltssm_timeout_timer;
  logic       clk = 1'b0;
  logic       reset, enableTimer, resetTimer;
  logic [5:0] setTimer;
  logic       timeOut, timerBusy, timerCodeErr;
  int         n_chk = 0, n_pass = 0;
  logic [2:0] exp_q[$];
  string      tag_q[$];
  always #5 clk = ~clk;
  ltssm_timeout_timer #(.CYCLES_PER_MS(4), .SIM_CYCLES_PER_MS(4), .MS_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .setTimer    (setTimer),
    .enableTimer (enableTimer),
    .resetTimer  (resetTimer),
    .timeOut     (timeOut),
    .timerBusy   (timerBusy),
    .timerCodeErr(timerCodeErr)
  );
  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: {timeOut,timerBusy,timerCodeErr} got=%b exp=%b at %0t", tag, got, exp, $time);
  endtask
  task automatic cyc(input logic rn, input logic rt, input logic en, input logic [5:0] code,
                     input logic [2:0] exp, input string tag);
    reset = rn;
    resetTimer = rt;
    enableTimer = en;
    setTimer = code;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    chk(tag_q.pop_front(), {timeOut, timerBusy, timerCodeErr}, exp_q.pop_front());
  endtask
  task automatic arm_run(input logic [5:0] code, input int ms, input int pstart, input int plen,
                         input string tag);
    int total;
    logic en;
    total = ms * 4 + plen;
    cyc(1, 0, 1, code, 3'b010, {tag, "_arm"});
    for (int k = 1; k <= total; k++) begin
      en = !(plen > 0 && k >= pstart && k < pstart + plen);
      cyc(1, 0, en, code, k == total ? 3'b100 : 3'b010, tag);
    end
  endtask
  initial begin
    cyc(0, 0, 0, 0, 3'b000, "rst0");
    cyc(0, 0, 1, 3, 3'b000, "rst1");
    cyc(1, 0, 0, 3, 3'b000, "idle");
    cyc(1, 0, 1, 0, 3'b000, "code_off");
    arm_run(TMR_CODE(3), 24, 0, 0, "run24");
    for (int i = 0; i < 3; i++) cyc(1, 0, i[0], 6'd3, 3'b100, "hold24");
    cyc(1, 1, 0, 0, 3'b000, "clr24");
    arm_run(TMR_CODE(1), 2, 3, 5, "pause2");
    cyc(1, 1, 0, 0, 3'b000, "clr2");
    cyc(1, 0, 1, 9, 3'b001, "rsvd");
    cyc(1, 0, 1, 63, 3'b001, "rsvd_sticky");
    cyc(1, 0, 0, 0, 3'b001, "rsvd_hold");
    cyc(1, 1, 0, 0, 3'b000, "clr_err");
    arm_run(TMR_CODE(5), 1, 0, 0, "run1");
    for (int i = 0; i < 4; i++) cyc(1, 0, i[0], 6'd4, 3'b100, "hold1");
    cyc(1, 1, 1, 4, 3'b000, "clr1");
    arm_run(TMR_CODE(4), 48, 0, 0, "run48");
    cyc(1, 1, 0, 0, 3'b000, "clr48");
    cyc(1, 0, 1, 5, 3'b010, "race_arm");
    for (int k = 1; k < 4; k++) cyc(1, 0, 1, 5, 3'b010, "race_run");
    cyc(1, 1, 1, 5, 3'b000, "race_clr");
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 5, 3'b000, "race_idle");
    cyc(1, 1, 1, 3, 3'b000, "clr_vs_arm");
    cyc(1, 0, 1, 3, 3'b010, "arm_after_clr");
    cyc(1, 1, 0, 3, 3'b000, "clr_again");
    cyc(1, 0, 1, 4, 3'b010, "mid_arm");
    for (int k = 1; k < 50; k++) cyc(1, 0, 1, 4, 3'b010, "mid_run");
    cyc(0, 0, 1, 4, 3'b000, "mid_rst");
    for (int k = 0; k < 200; k++) cyc(1, 0, 0, 4, 3'b000, "post_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  function automatic logic [5:0] TMR_CODE(input int c);
    return 6'(c);
  endfunction
endmodule
